// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller.
//   - fir_state_e : controller state encoding (IDLE/LOAD/FLUSH/RUN)
//   - DEFAULT_DATAWIDTH, DEFAULT_N : default sample width and tap count
//   - clog2 : ceiling log2, used to size counters
package fir_pkg;

    localparam int unsigned DEFAULT_DATAWIDTH = 8;
    localparam int unsigned DEFAULT_N         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } fir_state_e;

    // Ceiling log2; clog2(1) = 0, so callers must pass values >= 2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_valid_pipe.sv
// LAT-deep valid shift register with synchronous clear.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of every stage
//   din      : valid bit entering the pipeline
//   dout     : valid bit leaving the pipeline (LAT cycles after din)
module fir_valid_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr;

    // Shift towards the MSB; the LAT-bit truncation drops the oldest stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= LAT'({sr, din});
        end
    end

    assign dout = sr[LAT-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for the FIR_filter datapath: loads N coefficients,
// flushes the filter delay line with zeros, gates samples in, and tags
// filter outputs with m_valid after LAT cycles.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cfg_start                    : request coefficient reload
//   cfg_valid/cfg_data/cfg_ready : coefficient load handshake (tap 0 first)
//   s_valid/s_data/s_ready       : input sample handshake
//   fir_en, fir_x, fir_coef      : drive to FIR_filter
//   fir_y                        : FIR_filter output
//   m_valid, m_data              : tagged filter output (no backpressure)
//   busy                         : registered, high in LOAD and FLUSH
//   sample_cnt                   : accepted-sample count, only when the
//                                  FIR_SEQ_CNT_EN macro is defined
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned datawidth = DEFAULT_DATAWIDTH,
    parameter int unsigned N         = DEFAULT_N,
    parameter int unsigned LAT       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [datawidth-1:0]     cfg_data,
    output logic                     cfg_ready,
    input  logic                     s_valid,
    input  logic [datawidth-1:0]     s_data,
    output logic                     s_ready,
    output logic                     fir_en,
    output logic [datawidth-1:0]     fir_x,
    output logic [N*datawidth-1:0]   fir_coef,
    input  logic [datawidth-1:0]     fir_y,
    output logic                     m_valid,
    output logic [datawidth-1:0]     m_data,
    output logic                     busy
`ifdef FIR_SEQ_CNT_EN
    ,
    output logic [15:0]              sample_cnt
`endif
);

    localparam int unsigned IDXW = clog2(N);
    localparam int unsigned FCW  = clog2(N + 1);

    fir_state_e      state_q, state_d;
    logic [IDXW-1:0] idx_q;
    logic [FCW-1:0]  fcnt_q;
    logic            wr;
    logic            accept;
    logic            load_entry;

    // Next state and handshake/filter drive; s_ready and fir_en must react
    // in the same cycle as the transfer they qualify.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        fir_en    = 1'b0;
        fir_x     = '0;
        wr        = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) state_d = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                wr        = cfg_valid;
                if (cfg_valid && (idx_q == IDXW'(N - 1))) state_d = FLUSH;
            end
            FLUSH: begin
                fir_en = 1'b1;
                if (fcnt_q == FCW'(N - 1)) state_d = RUN;
            end
            RUN: begin
                // A reload request wins over a sample in the same cycle.
                s_ready = !cfg_start;
                accept  = s_valid && !cfg_start;
                fir_en  = accept;
                fir_x   = accept ? s_data : '0;
                if (cfg_start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_entry = (state_d == LOAD) && (state_q != LOAD);

    // State, counters, coefficient store and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            fcnt_q   <= '0;
            fir_coef <= '0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == LOAD) || (state_d == FLUSH);
            if (wr) begin
                fir_coef[int'(idx_q)*datawidth +: datawidth] <= cfg_data;
                idx_q <= (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);
            end
            if (state_q == FLUSH) begin
                fcnt_q <= (fcnt_q == FCW'(N - 1)) ? '0 : fcnt_q + FCW'(1);
            end
        end
    end

    fir_valid_pipe #(.LAT(LAT)) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_entry),
        .din  (accept),
        .dout (m_valid)
    );

    assign m_data = m_valid ? fir_y : '0;

`ifdef FIR_SEQ_CNT_EN
    // Accepted-sample counter, restarted with every reconfiguration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (load_entry) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: directed scenarios followed by
// random traffic, compared cycle by cycle against a behavioural model.
// A behavioural FIR filter (LAT = 1) closes the loop on fir_y.
module tb_fir_seq_ctrl;

    localparam int DW   = 8;
    localparam int NT   = 4;
    localparam int LATC = 1;

    logic             clk;
    logic             rst;
    logic             cfg_start;
    logic             cfg_valid;
    logic [DW-1:0]    cfg_data;
    logic             cfg_ready;
    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_ready;
    logic             fir_en;
    logic [DW-1:0]    fir_x;
    logic [NT*DW-1:0] fir_coef;
    logic [DW-1:0]    fir_y = '0;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             busy;
`ifdef FIR_SEQ_CNT_EN
    logic [15:0]      sample_cnt;
`endif

    fir_seq_ctrl #(.datawidth(DW), .N(NT), .LAT(LATC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .fir_en    (fir_en),
        .fir_x     (fir_x),
        .fir_coef  (fir_coef),
        .fir_y     (fir_y),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .busy      (busy)
`ifdef FIR_SEQ_CNT_EN
        ,
        .sample_cnt(sample_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIR filter: one register stage, truncated signed sum.
    logic [DW-1:0] fdl [NT-1] = '{default: '0};
    always @(posedge clk) begin : filt
        int s;
        if (fir_en) begin
            s = $signed(fir_x) * $signed(fir_coef[DW-1:0]);
            for (int k = 1; k < NT; k++)
                s += $signed(fdl[k-1]) * $signed(fir_coef[k*DW +: DW]);
            fir_y  <= DW'(s);
            fdl[0] <= fir_x;
            for (int k = 1; k < NT - 1; k++) fdl[k] <= fdl[k-1];
        end
    end

    // Reference model state.
    typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_RUN} mode_e;
    mode_e         mode;
    int            m_idx;
    int            m_fl;
    logic [DW-1:0] m_coef [NT];
    logic [DW-1:0] m_dl   [NT-1];
    logic [DW-1:0] m_y;
    bit            m_pipe [LATC];
    int            m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed per-step values for the directed scenarios.
    bit            obs_busy, obs_en, obs_mv;
    logic [DW-1:0] obs_x, obs_md;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode  = M_IDLE;
        m_idx = 0;
        m_fl  = 0;
        m_cnt = 0;
        for (int k = 0; k < NT; k++) m_coef[k] = '0;
        for (int i = 0; i < LATC; i++) m_pipe[i] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
        check({tag, "_s_ready"},   64'(s_ready),   64'd0);
        check({tag, "_fir_en"},    64'(fir_en),    64'd0);
        check({tag, "_fir_x"},     64'(fir_x),     64'd0);
        check({tag, "_m_valid"},   64'(m_valid),   64'd0);
        check({tag, "_m_data"},    64'(m_data),    64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_fir_coef"},  64'(fir_coef),  64'd0);
`ifdef FIR_SEQ_CNT_EN
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
`endif
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model to what the next cycle should look like.
    task automatic step(input bit cs, input bit cv, input logic [DW-1:0] cd,
                        input bit sv, input logic [DW-1:0] sd);
        bit            e_cr, e_sr, acc, e_en, e_busy, e_mv, enter_load;
        logic [DW-1:0] e_x, e_md;
        logic [NT*DW-1:0] e_coef;
        int            s;
        @(negedge clk);
        cfg_start = cs;
        cfg_valid = cv;
        cfg_data  = cd;
        s_valid   = sv;
        s_data    = sd;
        #1;
        e_cr   = (mode == M_LOAD);
        e_sr   = (mode == M_RUN) && !cs;
        acc    = sv && e_sr;
        e_en   = (mode == M_FLUSH) || acc;
        e_x    = acc ? sd : '0;
        e_busy = (mode == M_LOAD) || (mode == M_FLUSH);
        e_mv   = m_pipe[LATC-1];
        e_md   = e_mv ? m_y : '0;
        for (int k = 0; k < NT; k++) e_coef[k*DW +: DW] = m_coef[k];

        check("cfg_ready", 64'(cfg_ready), 64'(e_cr));
        check("s_ready",   64'(s_ready),   64'(e_sr));
        check("fir_en",    64'(fir_en),    64'(e_en));
        check("fir_x",     64'(fir_x),     64'(e_x));
        check("busy",      64'(busy),      64'(e_busy));
        check("m_valid",   64'(m_valid),   64'(e_mv));
        check("m_data",    64'(m_data),    64'(e_md));
        check("fir_coef",  64'(fir_coef),  64'(e_coef));
`ifdef FIR_SEQ_CNT_EN
        check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
`endif
        obs_busy = busy;
        obs_en   = fir_en;
        obs_x    = fir_x;
        obs_mv   = m_valid;
        obs_md   = m_data;

        // Filter: y is the dot product of coefficients with the new window.
        if (e_en) begin
            s = $signed(e_x) * $signed(m_coef[0]);
            for (int k = 1; k < NT; k++) s += $signed(m_dl[k-1]) * $signed(m_coef[k]);
            m_y = DW'(s);
            for (int k = NT - 2; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = e_x;
        end

        enter_load = 1'b0;
        case (mode)
            M_IDLE: if (cs) begin mode = M_LOAD; enter_load = 1'b1; end
            M_LOAD: if (cv) begin
                m_coef[m_idx] = cd;
                m_idx++;
                if (m_idx == NT) begin m_idx = 0; m_fl = 0; mode = M_FLUSH; end
            end
            M_FLUSH: begin
                m_fl++;
                if (m_fl == NT) mode = M_RUN;
            end
            M_RUN: if (cs) begin mode = M_LOAD; enter_load = 1'b1; end
            default: mode = M_IDLE;
        endcase

        if (enter_load) begin
            for (int i = 0; i < LATC; i++) m_pipe[i] = 1'b0;
            m_cnt = 0;
        end else begin
            for (int i = LATC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = acc;
            if (acc) m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset(input string tag);
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        #2 rst = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_coefs(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                              input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        step(1, 0, '0, 0, '0);
        step(0, 1, c0, 0, '0);
        step(0, 1, c1, 0, '0);
        step(0, 1, c2, 0, '0);
        step(0, 1, c3, 0, '0);
        for (int i = 0; i < NT; i++) step(0, 0, '0, 0, '0);
    endtask

    initial begin : main
        int busy_cycles, flush_en, mv_cycles;
        logic [DW-1:0] mseq [4];
        logic [DW-1:0] exp_seq [4];

        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        for (int k = 0; k < NT - 1; k++) m_dl[k] = '0;
        m_y = '0;
        model_reset();
        rst = 1'b1;
        #3;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Reset after two of four coefficient writes.
        step(1, 0, '0, 0, '0);
        step(0, 1, 8'h11, 0, '0);
        step(0, 1, 8'h22, 0, '0);
        do_reset("rst_mid_load");

        // Load 1,2,3,4 with continuous cfg_valid, then flush.
        busy_cycles = 0;
        flush_en    = 0;
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < NT; i++) begin
            step(0, 1, DW'(i + 1), 0, '0);
            busy_cycles += int'(obs_busy);
        end
        for (int i = 0; i < NT; i++) begin
            step(1, 0, '0, 0, '0);
            busy_cycles += int'(obs_busy);
            if (obs_en && obs_x == '0) flush_en++;
        end
        check("load_coef_word", 64'(fir_coef), 64'h04030201);
        check("load_busy_cycles", 64'(busy_cycles), 64'd8);
        check("flush_zero_en_cycles", 64'(flush_en), 64'd4);
        step(0, 0, '0, 0, '0);
        check("run_s_ready", 64'(obs_en), 64'd0);
        check("run_s_ready_high", 64'(s_ready), 64'd1);

        // Impulse response through the behavioural filter.
        mv_cycles = 0;
        exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4};
        step(0, 0, '0, 1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 1, 8'd0);
            if (obs_mv) begin mseq[mv_cycles] = obs_md; mv_cycles++; end
        end
        step(0, 0, '0, 0, '0);
        if (obs_mv) begin mseq[mv_cycles] = obs_md; mv_cycles++; end
        check("impulse_mv_cycles", 64'(mv_cycles), 64'd4);
        for (int i = 0; i < mv_cycles && i < 4; i++)
            check("impulse_m_data", 64'(mseq[i]), 64'(exp_seq[i]));
        step(0, 0, '0, 0, '0);

        // Gapped input.
        for (int i = 0; i < 6; i++) step(0, 0, '0, (i % 2) == 0, DW'($urandom));

        // Reload requested together with a sample.
        step(0, 0, '0, 1, 8'd5);
        step(1, 0, '0, 1, 8'd6);
        check("simul_no_fir_en", 64'(obs_en), 64'd0);
        step(0, 0, '0, 0, '0);
        check("simul_mv_dropped", 64'(obs_mv), 64'd0);
        for (int i = 0; i < NT; i++) step(0, 1, DW'($urandom), 0, '0);
        for (int i = 0; i < NT; i++) step(0, 0, '0, 0, '0);

        // Five accepted samples, then reload.
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, DW'($urandom));
        step(1, 0, '0, 0, '0);
`ifdef FIR_SEQ_CNT_EN
        check("cnt_five", 64'(sample_cnt), 64'd5);
`endif
        step(0, 0, '0, 0, '0);
`ifdef FIR_SEQ_CNT_EN
        check("cnt_cleared", 64'(sample_cnt), 64'd0);
`endif
        load_coefs(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, DW'($urandom),
                 $urandom_range(0, 1) == 1, DW'($urandom));
            if (i == 1500) do_reset("rst_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencing controller for the FIR_filter datapath.
- Loads the N signed coefficients through a valid/ready config port.
- Flushes the filter delay line with zeros after every reconfiguration.
- Gates input samples into the filter with a valid/ready handshake.
- Tags filter outputs with m_valid after a fixed pipeline latency.

Sits between the sample source/config master and FIR_filter.

Parameters:
- datawidth, 8, bit-width of samples, coefficients and filter output (signed)
- N, 4, number of filter coefficients (taps), >=2
- LAT, 1, clock cycles from fir_en sample acceptance to valid fir_y, >=1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  request coefficient reload
- cfg_valid  in  1  coefficient word valid
- cfg_data  in  datawidth  signed coefficient word, index 0 first
- cfg_ready  out  1  controller accepts coefficient word
- s_valid  in  1  input sample valid
- s_data  in  datawidth  signed input sample
- s_ready  out  1  controller accepts sample
- fir_en  out  1  advance filter delay line this cycle
- fir_x  out  datawidth  sample driven to filter x_in
- fir_coef  out  N*datawidth  flattened coefficients, tap k at [k*datawidth +: datawidth]
- fir_y  in  datawidth  filter output y_out
- m_valid  out  1  m_data holds the output for an accepted sample
- m_data  out  datawidth  forwarded fir_y
- busy  out  1  state is LOAD or FLUSH

Behaviour:
Reset (async, rst=1):
- State=IDLE; fir_coef=0; coefficient index=0; flush count=0; valid pipeline=0.
- All outputs 0: cfg_ready, s_ready, fir_en, fir_x, m_valid, m_data, busy.

FSM states: IDLE, LOAD, FLUSH, RUN.
- IDLE: waits for cfg_start=1, then goes to LOAD next cycle. Samples are refused (s_ready=0).
- LOAD:
  - cfg_ready=1.
  - Each cfg_valid&cfg_ready writes cfg_data into tap[idx], then idx++.
  - On the Nth write, idx wraps to 0 and the next state is FLUSH.
  - fir_en=0 throughout.
  - cfg_start in LOAD is ignored; the load is never restarted mid-way.
- FLUSH:
  - fir_en=1, fir_x=0 for exactly N consecutive cycles, then RUN.
  - s_ready=0, cfg_ready=0, cfg_start ignored.
- RUN:
  - s_ready = !cfg_start (combinational).
  - On s_valid&s_ready: fir_en=1, fir_x=s_data.
  - Otherwise fir_en=0, fir_x=0.
  - cfg_start=1 wins over a simultaneous sample: the sample is not accepted, and the next state is LOAD.

Busy and valid pipeline:
- busy is registered state decode: 1 in LOAD and FLUSH.
- Valid pipeline is an LAT-deep shift register, advancing every clk, fed by s_valid&s_ready.
- m_valid = pipeline tail.
- m_data = fir_y when m_valid, else 0.
- Flush zeros never produce m_valid.
- Entering LOAD clears the valid pipeline; in-flight results are discarded.
- Coefficients are only modified in LOAD and hold their value in all other states.
- Arithmetic: no arithmetic on data; cfg_data and s_data pass through unmodified (signed, no extension).
- Counters: idx width is clog2(N); flush counter width is clog2(N+1).
- No output backpressure: the consumer must accept m_valid every cycle.

Optional Feature:
FIR_SEQ_CNT_EN
- Defined:
  - Adds output port sample_cnt [15:0], counting accepted samples (s_valid&s_ready).
  - Cleared by rst and on entry to LOAD; wraps 16'hFFFF->0.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding typedef (IDLE=0, LOAD=1, FLUSH=2, RUN=3);
  - default DATAWIDTH=8 and N=4 constants;
  - a clog2 helper.
- One natural sub-module: fir_valid_pipe (LAT-deep shift register with synchronous clear), instantiated once.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: after 2 of 4 coefficient writes, pulse rst.
  - Required: fir_coef=0, state IDLE, and all outputs 0 immediately (async).
- Load and flush:
  - Stimulus: cfg_start, then write 1,2,3,4.
  - Required: fir_coef=32'h04030201; exactly 4 cycles of fir_en=1/fir_x=0; busy=1 for 8 cycles in total (4 LOAD with continuous cfg_valid, 4 FLUSH); then s_ready=1.
- Impulse through a real FIR_filter with LAT=1:
  - Stimulus: send 1,0,0,0 on consecutive cycles.
  - Required: m_valid high for 4 cycles, m_data=1,2,3,4.
- Gapped input:
  - Stimulus: s_valid toggles 1,0,1,0.
  - Required: fir_en mirrors acceptance; m_valid pattern is the accept pattern delayed by LAT.
- Simultaneous events:
  - Stimulus: cfg_start and s_valid in the same RUN cycle.
  - Required: s_ready=0, no fir_en, next state LOAD, and a pending m_valid is dropped.
- FIR_SEQ_CNT_EN:
  - Stimulus: 5 accepted samples, then cfg_start.
  - Required: sample_cnt reads 5, then 0 after entering LOAD.
